looping_pattern_generator: RTL and testbench
============================================

LOOPING_PATTERN_GENERATOR -- requirements
Module: looping_pattern_generator

Interface
REQ-001 SHALL have parameters: NUM_SIG=16, signals per sample; NUM_SAMP=256, buffer depth in samples (power of 2); DIV_W=16, clock-divider width; AW=$clog2(NUM_SAMP), derived.
REQ-002 SHALL use one clock; reset is asynchronous and active-low; ports: axi_clk in 1, sole clock; axi_resetn in 1, async active-low reset.
REQ-003 SHALL have ports: wr_valid in 1, write-sample request; wr_data in NUM_SIG, sample; wr_ready out 1, write accepted.
REQ-004 SHALL have ports: run in 1, start pulse; stop in 1, abort pulse; clear in 1, empty buffer and clear errors.
REQ-005 SHALL have ports: mode in 2, 0=one-shot, 1=loop-N, 2=continuous, 3=one-shot; loop_count in 16, extra passes in loop-N; n_samples in AW+1, pattern length; clk_div in DIV_W, tick period minus 1.
REQ-006 SHALL have ports: output_signals out NUM_SIG, pattern; input_signals in NUM_SIG, captured lines.
REQ-007 SHALL have ports: rd_strobe in 1, capture-read request; rd_data out NUM_SIG, captured sample; rd_valid out 1, rd_data valid.
REQ-008 SHALL have ports: busy out 1; done out 1; write_buffer_len out AW+1; wave_ptr out AW; loop_iter out 16; sample_count out 32; err out 2, sticky: bit0 write dropped, bit1 bad run length.

Function
REQ-009 SHALL implement states IDLE, RUN, DONE; busy=1 only in RUN; done=1 only in DONE.
REQ-010 SHALL drive wr_ready = (state!=RUN) and (write_buffer_len<NUM_SAMP); wr_valid with wr_ready stores wr_data at index write_buffer_len, which increments at that edge.
REQ-011 SHALL drop wr_valid without wr_ready and set err[0].
REQ-012 SHALL, on clear outside RUN, zero write_buffer_len and err and enter IDLE at the next edge; clear in RUN is ignored.
REQ-013 SHALL, on run outside RUN with 1<=n_samples<=write_buffer_len, enter RUN and zero wave_ptr, loop_iter, sample_count, divider and capture read pointer; otherwise set err[1] and stay put.
REQ-014 SHALL generate a tick on the first RUN cycle and every clk_div+1 cycles after; clk_div=0 ticks every cycle.
REQ-015 SHALL, on each tick, register buffer[wave_ptr] onto output_signals (1-cycle latency) and increment sample_count, saturating at 0xFFFFFFFF; with run seen at edge k, sample i appears after edge k+1+i*(clk_div+1).
REQ-016 SHALL, on a tick with wave_ptr==n_samples-1: one-shot -> DONE; loop-N -> DONE if loop_iter==loop_count, else wave_ptr=0 and loop_iter+1; continuous -> wave_ptr=0, loop_iter+1 wrapping at 16 bits; otherwise wave_ptr+1.
REQ-017 SHALL, on stop in RUN, enter IDLE at the next edge without setting done; stop and run together -> stop wins.
REQ-018 SHALL hold output_signals at the last driven sample in IDLE and DONE.
REQ-019 SHALL ignore mode, n_samples, loop_count and clk_div changes during RUN; they are latched on the run edge.

Reset
REQ-020 SHALL, on axi_resetn low, asynchronously force IDLE and zero all outputs, counters, pointers, err and capture pointers, including mid-RUN; buffer contents are not reset.
REQ-021 SHALL start accepting writes and run on the first edge after axi_resetn deasserts.

Configuration
REQ-022 SHALL compile input capture in only when PATGEN_CAPTURE_EN is defined.
REQ-023 SHALL, with PATGEN_CAPTURE_EN, store input_signals into capture[wave_ptr] on each first-pass tick (loop_iter==0); later passes do not overwrite.
REQ-024 SHALL, with PATGEN_CAPTURE_EN, return capture[rd_ptr] on rd_data with rd_valid one cycle after rd_strobe, then increment rd_ptr, wrapping to 0 at n_samples-1.
REQ-025 SHALL, without PATGEN_CAPTURE_EN, hold rd_data=0 and rd_valid=0, infer no capture memory, and keep all other behaviour identical.

Verification
REQ-026 SHALL cover: write 4 samples 0x1,0x2,0x4,0x8, n_samples=4, mode=0, clk_div=0, run -> outputs 1,2,4,8 on consecutive cycles, then done=1, output holds 0x8.
REQ-027 SHALL cover: same buffer, mode=1, loop_count=2, clk_div=3 -> 12 ticks spaced 4 cycles, loop_iter ends at 2, sample_count=12, done=1.
REQ-028 SHALL cover: fill NUM_SAMP samples, one more wr_valid -> wr_ready=0, err[0]=1, write_buffer_len=NUM_SAMP; clear -> both 0.
REQ-029 SHALL cover: write_buffer_len=3, n_samples=5, run -> err[1]=1, state IDLE, outputs unchanged.
REQ-030 SHALL cover: mode=2 running, assert stop and run in the same cycle -> IDLE next edge, done=0; axi_resetn low mid-RUN -> all outputs 0 immediately.
REQ-031 SHALL cover: with PATGEN_CAPTURE_EN, input_signals=0xA5A0+wave_ptr during one-shot run of 4 samples, then 4 rd_strobes -> rd_data 0xA5A0..0xA5A3, rd_valid each one cycle later.

Source files
------------

// File: rtl/looping_pattern_generator.sv
// Looping pattern generator: plays a written sample buffer out as one-shot, loop-N or continuous.
// Define PATGEN_CAPTURE_EN to compile in first-pass input capture with a strobed read port.
module looping_pattern_generator #(
    parameter int NUM_SIG  = 16,
    parameter int NUM_SAMP = 256,
    parameter int DIV_W    = 16,
    parameter int AW       = $clog2(NUM_SAMP)
) (
    input  logic               axi_clk,
    input  logic               axi_resetn,
    input  logic               wr_valid,
    input  logic [NUM_SIG-1:0] wr_data,
    output logic               wr_ready,
    input  logic               run,
    input  logic               stop,
    input  logic               clear,
    input  logic [1:0]         mode,
    input  logic [15:0]        loop_count,
    input  logic [AW:0]        n_samples,
    input  logic [DIV_W-1:0]   clk_div,
    output logic [NUM_SIG-1:0] output_signals,
    input  logic [NUM_SIG-1:0] input_signals,
    input  logic               rd_strobe,
    output logic [NUM_SIG-1:0] rd_data,
    output logic               rd_valid,
    output logic               busy,
    output logic               done,
    output logic [AW:0]        write_buffer_len,
    output logic [AW-1:0]      wave_ptr,
    output logic [15:0]        loop_iter,
    output logic [31:0]        sample_count,
    output logic [1:0]         err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [AW:0] DEPTH = (AW+1)'(NUM_SAMP);

    state_t             state;
    logic [1:0]         mode_q;
    logic [15:0]        loops_q;
    logic [AW:0]        n_q;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_cnt;
    logic [NUM_SIG-1:0] buffer [NUM_SAMP];

    logic wr_fire;
    logic run_ok;
    logic run_start;
    logic tick;
    logic last_samp;

    assign wr_ready  = (state != RUN) && (write_buffer_len < DEPTH);
    assign wr_fire   = wr_valid && wr_ready;
    assign run_ok    = (n_samples != '0) && (n_samples <= write_buffer_len);
    assign run_start = (state != RUN) && !clear && run && run_ok;
    // A stop in RUN pre-empts any tick that would have fired in the same cycle.
    assign tick      = (state == RUN) && (div_cnt == '0) && !stop;
    assign last_samp = ({1'b0, wave_ptr} == (n_q - (AW+1)'(1)));
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    // NOTE: the pattern memory has no reset so it maps onto plain RAM; its contents only matter once written.
    always_ff @(posedge axi_clk) begin
        if (wr_fire) buffer[write_buffer_len[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state            <= IDLE;
            mode_q           <= '0;
            loops_q          <= '0;
            n_q              <= '0;
            div_q            <= '0;
            div_cnt          <= '0;
            output_signals   <= '0;
            write_buffer_len <= '0;
            wave_ptr         <= '0;
            loop_iter        <= '0;
            sample_count     <= '0;
            err              <= '0;
        end else begin
            // NOTE: later non-blocking assignments win, so clear below overrides the err/len updates here.
            if (wr_valid && !wr_ready) err[0] <= 1'b1;
            if (wr_fire) write_buffer_len <= write_buffer_len + (AW+1)'(1);

            case (state)
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else begin
                        div_cnt <= (div_cnt == div_q) ? '0 : div_cnt + DIV_W'(1);
                        if (tick) begin
                            output_signals <= buffer[wave_ptr];
                            if (sample_count != '1) sample_count <= sample_count + 32'd1;
                            if (last_samp) begin
                                case (mode_q)
                                    2'd1: begin
                                        if (loop_iter == loops_q) begin
                                            state <= DONE;
                                        end else begin
                                            wave_ptr  <= '0;
                                            loop_iter <= loop_iter + 16'd1;
                                        end
                                    end
                                    2'd2: begin
                                        wave_ptr  <= '0;
                                        loop_iter <= loop_iter + 16'd1;
                                    end
                                    default: state <= DONE;
                                endcase
                            end else begin
                                wave_ptr <= wave_ptr + AW'(1);
                            end
                        end
                    end
                end
                default: begin
                    if (clear) begin
                        state            <= IDLE;
                        write_buffer_len <= '0;
                        err              <= '0;
                    end else if (run_start) begin
                        state        <= RUN;
                        mode_q       <= mode;
                        loops_q      <= loop_count;
                        n_q          <= n_samples;
                        div_q        <= clk_div;
                        div_cnt      <= '0;
                        wave_ptr     <= '0;
                        loop_iter    <= '0;
                        sample_count <= '0;
                    end else if (run) begin
                        err[1] <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef PATGEN_CAPTURE_EN
    logic [NUM_SIG-1:0] capture [NUM_SAMP];
    logic [AW-1:0]      rd_ptr;

    always_ff @(posedge axi_clk) begin
        if (tick && (loop_iter == '0)) capture[wave_ptr] <= input_signals;
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_strobe;
            if (run_start) begin
                rd_ptr <= '0;
            end else if (rd_strobe) begin
                rd_data <= capture[rd_ptr];
                rd_ptr  <= ({1'b0, rd_ptr} == (n_q - (AW+1)'(1))) ? '0 : rd_ptr + AW'(1);
            end
        end
    end
`else
    logic unused_capture;

    assign unused_capture = ^{rd_strobe, input_signals};
    assign rd_data        = '0;
    assign rd_valid       = 1'b0;
`endif

endmodule

// File: tb/tb_looping_pattern_generator.sv
// Self-checking bench for looping_pattern_generator: directed scenarios plus randomized runs
// compared against an expected playback sequence computed from the sample list.
module tb_looping_pattern_generator;
    localparam int NUM_SIG  = 16;
    localparam int NUM_SAMP = 256;
    localparam int DIV_W    = 16;
    localparam int AW       = $clog2(NUM_SAMP);

    logic               axi_clk = 1'b0;
    logic               axi_resetn = 1'b0;
    logic               wr_valid = 1'b0;
    logic [NUM_SIG-1:0] wr_data = '0;
    logic               wr_ready;
    logic               run = 1'b0;
    logic               stop = 1'b0;
    logic               clear = 1'b0;
    logic [1:0]         mode = '0;
    logic [15:0]        loop_count = '0;
    logic [AW:0]        n_samples = '0;
    logic [DIV_W-1:0]   clk_div = '0;
    logic [NUM_SIG-1:0] output_signals;
    logic [NUM_SIG-1:0] input_signals;
    logic               rd_strobe = 1'b0;
    logic [NUM_SIG-1:0] rd_data;
    logic               rd_valid;
    logic               busy;
    logic               done;
    logic [AW:0]        write_buffer_len;
    logic [AW-1:0]      wave_ptr;
    logic [15:0]        loop_iter;
    logic [31:0]        sample_count;
    logic [1:0]         err;

    looping_pattern_generator #(
        .NUM_SIG(NUM_SIG), .NUM_SAMP(NUM_SAMP), .DIV_W(DIV_W)
    ) dut (
        .axi_clk(axi_clk), .axi_resetn(axi_resetn),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .run(run), .stop(stop), .clear(clear),
        .mode(mode), .loop_count(loop_count), .n_samples(n_samples), .clk_div(clk_div),
        .output_signals(output_signals), .input_signals(input_signals),
        .rd_strobe(rd_strobe), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .write_buffer_len(write_buffer_len),
        .wave_ptr(wave_ptr), .loop_iter(loop_iter), .sample_count(sample_count), .err(err)
    );

    always #5 axi_clk = ~axi_clk;

    assign input_signals = 16'hA5A0 + 16'(wave_ptr);

    int n_checks = 0;
    int n_fail   = 0;

    logic [NUM_SIG-1:0] model [$];
    logic [NUM_SIG-1:0] last_out = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_sample(input logic [NUM_SIG-1:0] data);
        check("wr_ready_before_write", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_data  = data;
        @(negedge axi_clk);
        wr_valid = 1'b0;
        model.push_back(data);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge axi_clk);
        clear = 1'b0;
        model.delete();
        check("clear_len", 32'(write_buffer_len), 32'd0);
        check("clear_err", 32'(err), 32'd0);
        check("clear_done", 32'(done), 32'd0);
    endtask

    // Expected playback: tick j lands after run edge + 1 + j*(d+1), showing model[j mod n].
    task automatic run_and_check(input int n, input int md, input int loops, input int d);
        int passes;
        int total;
        int last_c;
        int j;
        passes = (md == 1) ? loops + 1 : 1;
        total  = n * passes;
        last_c = 1 + (total - 1) * (d + 1);
        n_samples  = (AW+1)'(n);
        mode       = 2'(md);
        loop_count = 16'(loops);
        clk_div    = DIV_W'(d);
        run = 1'b1;
        @(negedge axi_clk);
        run = 1'b0;
        mode       = 2'($urandom);
        n_samples  = (AW+1)'($urandom);
        loop_count = 16'($urandom);
        clk_div    = DIV_W'($urandom);
        check("run_busy", 32'(busy), 32'd1);
        for (int c = 1; c <= last_c + 2; c++) begin
            @(negedge axi_clk);
            j = (c - 1) / (d + 1);
            if (j > total - 1) j = total - 1;
            check("play_out", 32'(output_signals), 32'(model[j % n]));
            check("play_done", 32'(done), 32'(c >= last_c));
            check("play_busy", 32'(busy), 32'(c < last_c));
        end
        check("end_sample_count", sample_count, 32'(total));
        check("end_loop_iter", 32'(loop_iter), 32'(passes - 1));
        check("end_wave_ptr", 32'(wave_ptr), 32'(n - 1));
        last_out = model[(total - 1) % n];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n, md, loops, d;

        // Reset state
        repeat (2) @(negedge axi_clk);
        check("rst_out", 32'(output_signals), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_len", 32'(write_buffer_len), 32'd0);
        check("rst_sample_count", sample_count, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        axi_resetn = 1'b1;

        // One-shot of 1,2,4,8 back to back, then loop-N with divider
        write_sample(16'h1);
        write_sample(16'h2);
        write_sample(16'h4);
        write_sample(16'h8);
        check("len_after_4", 32'(write_buffer_len), 32'd4);
        run_and_check(4, 0, 0, 0);
        check("oneshot_hold", 32'(output_signals), 32'h8);
        run_and_check(4, 1, 2, 3);

        // Randomized buffers and configurations
        for (int t = 0; t < 4; t++) begin
            do_clear();
            n = $urandom_range(8, 2);
            for (int i = 0; i < n; i++) write_sample(NUM_SIG'($urandom));
            md    = (t == 3) ? 3 : int'($urandom_range(1, 0));
            loops = $urandom_range(2, 0);
            d     = $urandom_range(2, 0);
            run_and_check($urandom_range(n, 1), md, loops, d);
        end

        // Run length beyond buffered samples is rejected
        do_clear();
        for (int i = 0; i < 3; i++) write_sample(NUM_SIG'($urandom));
        n_samples = 5;
        mode      = 0;
        run = 1'b1;
        @(negedge axi_clk);
        run = 1'b0;
        check("badrun_err", 32'(err), 32'h2);
        check("badrun_busy", 32'(busy), 32'd0);
        check("badrun_done", 32'(done), 32'd0);
        check("badrun_out", 32'(output_signals), 32'(last_out));

        // Fill to capacity, overflow write, full-length playback, then clear
        do_clear();
        for (int i = 0; i < NUM_SAMP; i++) write_sample(NUM_SIG'($urandom));
        check("full_ready", 32'(wr_ready), 32'd0);
        check("full_len", 32'(write_buffer_len), 32'(NUM_SAMP));
        wr_valid = 1'b1;
        wr_data  = 16'hDEAD;
        @(negedge axi_clk);
        wr_valid = 1'b0;
        check("overflow_err", 32'(err), 32'h1);
        check("overflow_len", 32'(write_buffer_len), 32'(NUM_SAMP));
        run_and_check(NUM_SAMP, 0, 0, 0);
        do_clear();
        check("clear_ready", 32'(wr_ready), 32'd1);

        // Capture of input lines during a one-shot run
        for (int i = 0; i < 4; i++) write_sample(NUM_SIG'($urandom));
        run_and_check(4, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            rd_strobe = 1'b1;
            @(negedge axi_clk);
            rd_strobe = 1'b0;
`ifdef PATGEN_CAPTURE_EN
            check("cap_rd_valid", 32'(rd_valid), 32'd1);
            check("cap_rd_data", 32'(rd_data), 32'(16'hA5A0 + 16'(i)));
`else
            check("nocap_rd_valid", 32'(rd_valid), 32'd0);
            check("nocap_rd_data", 32'(rd_data), 32'd0);
`endif
            @(negedge axi_clk);
            check("cap_rd_valid_drop", 32'(rd_valid), 32'd0);
        end

        // Continuous mode, stop+run together, then async reset mid-run
        do_clear();
        for (int i = 0; i < 4; i++) write_sample(NUM_SIG'($urandom));
        n_samples = 4;
        mode      = 2;
        clk_div   = 1;
        run = 1'b1;
        @(negedge axi_clk);
        run = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge axi_clk);
            check("cont_out", 32'(output_signals), 32'(model[((c - 1) / 2) % 4]));
            check("cont_busy", 32'(busy), 32'd1);
        end
        check("cont_sample_count", sample_count, 32'd10);
        check("cont_loop_iter", 32'(loop_iter), 32'd2);
        stop = 1'b1;
        run  = 1'b1;
        @(negedge axi_clk);
        stop = 1'b0;
        run  = 1'b0;
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_done", 32'(done), 32'd0);
        run = 1'b1;
        @(negedge axi_clk);
        run = 1'b0;
        repeat (5) @(negedge axi_clk);
        check("rerun_busy", 32'(busy), 32'd1);
        #2 axi_resetn = 1'b0;
        #1;
        check("arst_out", 32'(output_signals), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_len", 32'(write_buffer_len), 32'd0);
        check("arst_wave_ptr", 32'(wave_ptr), 32'd0);
        check("arst_loop_iter", 32'(loop_iter), 32'd0);
        check("arst_sample_count", sample_count, 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_rd", 32'({rd_valid, rd_data}), 32'd0);
        @(negedge axi_clk);
        axi_resetn = 1'b1;
        model.delete();

        // Writes accepted on the first edge after reset release
        write_sample(16'h1234);
        check("post_rst_len", 32'(write_buffer_len), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
